uart_frame_rx: RTL

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// UART frame receiver: pops bytes from an upstream FIFO and decodes
// SOF/CMD/DATA0/DATA1/CHK frames with XOR checksum and inter-byte timeout.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_D0,
        GET_D1,
        GET_CHK
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
    } shadow_t;

endpackage

module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter logic [7:0] SOF    = 8'hA5,
    parameter int         TO_CYC = 650_000,
    parameter int         TO_BIT = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    output logic        frame_valid,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        err_chk,
    output logic        err_timeout
);

    state_t            state;
    shadow_t           sh;
    logic [TO_BIT-1:0] to_cnt;

    logic              pop;
    logic              to_hit;
    logic [7:0]        chk_calc;

    // Every present byte is consumed immediately, so the FIFO never stalls.
    assign pop      = ~rx_empty & ~reset;
    assign rd_uart  = pop;
    assign to_hit   = (to_cnt == TO_BIT'(TO_CYC - 1));
    assign chk_calc = sh.cmd ^ sh.d0 ^ sh.d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sh          <= '0;
            to_cnt      <= '0;
            frame_valid <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            cmd         <= 8'h00;
            data        <= 16'h0000;
        end else begin
            frame_valid <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;

            if (state == IDLE) begin
                to_cnt <= '0;
                if (pop && (r_data == SOF)) begin
                    state <= GET_CMD;
                end
            end else begin
                // A present byte beats an expiring timeout.
                unique case (1'b1)
                    pop: begin
                        to_cnt <= '0;
                        unique case (state)
                            GET_CMD: begin
                                sh.cmd <= r_data;
                                state  <= GET_D0;
                            end
                            GET_D0: begin
                                sh.d0 <= r_data;
                                state <= GET_D1;
                            end
                            GET_D1: begin
                                sh.d1 <= r_data;
                                state <= GET_CHK;
                            end
                            default: begin
                                state <= IDLE;
                                if (r_data == chk_calc) begin
                                    frame_valid <= 1'b1;
                                    cmd         <= sh.cmd;
                                    data        <= {sh.d0, sh.d1};
                                end else begin
                                    err_chk <= 1'b1;
                                end
                            end
                        endcase
                    end
                    (!pop && to_hit): begin
                        to_cnt      <= '0;
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end
                    (!pop && !to_hit): begin
                        to_cnt <= to_cnt + TO_BIT'(1);
                    end
                    default: begin
                        to_cnt <= to_cnt;
                    end
                endcase
            end
        end
    end

endmodule
